// File: rtl/universal_reg.sv
// WIDTH-bit universal register: hold/load/shift/rotate with async clear (clr) and preset (pre).
// Define UREG_COUNT_EN to add up/down counting in modes 110/111 and the tc flag.
module universal_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] PRE_VAL = '1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sl_in,
    input  logic             sr_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    logic [WIDTH-1:0] q_d, q_q;
    logic             preset;

    // Active-high preset qualified by clr: its rising edge also covers clr being
    // released while pre is still low, so q moves to PRE_VAL without a clock.
    assign preset = clr & ~pre;

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                3'b001:  q_d = d;
                3'b010:  q_d = {q_q[WIDTH-2:0], sl_in};
                3'b011:  q_d = {sr_in, q_q[WIDTH-1:1]};
                3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
`ifdef UREG_COUNT_EN
                3'b110:  q_d = q_q + WIDTH'(1);
                3'b111:  q_d = q_q - WIDTH'(1);
`endif
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr or posedge preset) begin
        if (!clr) begin
            q_q <= '0;
        end else if (preset) begin
            q_q <= PRE_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

`ifdef UREG_COUNT_EN
    assign tc = ((mode == 3'b110) && (q_q == '1)) || ((mode == 3'b111) && (q_q == '0));
`else
    assign tc = 1'b0;
`endif

endmodule

// File: tb/tb_universal_reg.sv
// Self-checking bench for universal_reg (WIDTH=8, PRE_VAL=8'hFF): directed cases plus
// randomized operations checked against an arithmetic reference model.
module tb_universal_reg;

    localparam int unsigned W    = 8;
    localparam int unsigned MOD  = 1 << W;
    localparam int unsigned HALF = MOD / 2;
    localparam int unsigned PV   = 8'hFF;

    logic         clk = 1'b0;
    logic         clr, pre, en, sl_in, sr_in;
    logic [2:0]   mode;
    logic [W-1:0] d, q, qb;
    logic         tc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    universal_reg #(.WIDTH(W), .PRE_VAL(8'hFF)) dut (
        .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode), .d(d),
        .sl_in(sl_in), .sr_in(sr_in), .q(q), .qb(qb), .tc(tc)
    );

    // Next value of the register as plain arithmetic on an unsigned integer.
    function automatic int unsigned model_next(int unsigned cur, bit e, int unsigned m,
                                               int unsigned dv, bit sl, bit sr);
        if (!e) return cur;
        case (m)
            1: return dv;
            2: return (cur * 2 + sl) % MOD;
            3: return cur / 2 + sr * HALF;
            4: return (cur * 2) % MOD + cur / HALF;
            5: return cur / 2 + (cur % 2) * HALF;
`ifdef UREG_COUNT_EN
            6: return (cur + 1) % MOD;
            7: return (cur + MOD - 1) % MOD;
`endif
            default: return cur;
        endcase
    endfunction

    function automatic bit model_tc(int unsigned cur, int unsigned m);
`ifdef UREG_COUNT_EN
        return (m == 6 && cur == MOD - 1) || (m == 7 && cur == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_q(string name, int unsigned exp);
        checks++;
        if (q !== W'(exp) || qb !== ~W'(exp)) begin
            errors++;
            $display("FAIL %s: q=%h qb=%h expected q=%h qb=%h", name, q, qb, W'(exp), ~W'(exp));
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; pre = 1'b1; en = 1'b0; mode = 3'b000; d = '0; sl_in = 1'b0; sr_in = 1'b0;
        #2;
        check_q("reset_clr", 0);
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: tc=%b expected 0", tc); end
        en = 1'b1; mode = 3'b001; d = 8'hA5;
        tick();
        check_q("reset_clk_ignored", 0);
    endtask

    task automatic test_load_shift();
        clr = 1'b1; en = 1'b1; mode = 3'b001; d = 8'hA5;
        tick();
        check_q("load_a5", 8'hA5);
        mode = 3'b010; sl_in = 1'b1;
        tick();
        check_q("shl_4b", 8'h4B);
        mode = 3'b101;
        tick();
        check_q("ror_a5", 8'hA5);
        mode = 3'b011; sr_in = 1'b0;
        tick();
        check_q("shr_52", 8'h52);
        mode = 3'b100;
        tick();
        check_q("rol_a4", 8'hA4);
        mode = 3'b000;
        tick();
        check_q("hold_a4", 8'hA4);
    endtask

    task automatic test_async();
        mode = 3'b001; d = 8'h3C; en = 1'b1;
        tick();
        check_q("async_load_3c", 8'h3C);
        mode = 3'b000;
        #1 pre = 1'b0;
        #1 check_q("async_pre", 8'hFF);
        clr = 1'b0;
        #1 check_q("async_clr_pre", 8'h00);
        clr = 1'b1;
        #1 check_q("async_clr_release", 8'hFF);
        mode = 3'b001; d = 8'h12;
        tick();
        check_q("async_pre_clk_ignored", 8'hFF);
        pre = 1'b1;
        #1 check_q("async_pre_release_hold", 8'hFF);
        tick();
        check_q("async_first_edge", 8'h12);
    endtask

    task automatic test_count();
        en = 1'b1; mode = 3'b001; d = 8'hFE;
        tick();
        mode = 3'b110;
`ifdef UREG_COUNT_EN
        tick();
        check_q("cnt_up_ff", 8'hFF);
        checks++;
        if (tc !== 1'b1) begin errors++; $display("FAIL cnt_tc_ff: tc=%b expected 1", tc); end
        tick();
        check_q("cnt_wrap_00", 8'h00);
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL cnt_tc_00: tc=%b expected 0", tc); end
        mode = 3'b111;
        #1;
        checks++;
        if (tc !== 1'b1) begin errors++; $display("FAIL cnt_tc_down: tc=%b expected 1", tc); end
        tick();
        check_q("cnt_down_wrap", 8'hFF);
        en = 1'b0; mode = 3'b110;
        #1;
        checks++;
        if (tc !== 1'b1) begin errors++; $display("FAIL cnt_tc_no_en: tc=%b expected 1", tc); end
        en = 1'b1;
`else
        mode = 3'b001; d = 8'h12;
        tick();
        mode = 3'b110;
        repeat (3) tick();
        check_q("cnt_off_hold_up", 8'h12);
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL cnt_off_tc: tc=%b expected 0", tc); end
        mode = 3'b111;
        tick();
        check_q("cnt_off_hold_down", 8'h12);
`endif
    endtask

    task automatic test_enable();
        en = 1'b1; mode = 3'b001; d = 8'h5A;
        tick();
        en = 1'b0; d = 8'h77;
        repeat (2) tick();
        check_q("en0_load_held", 8'h5A);
        en = 1'b1;
        #6 clr = 1'b0;
        tick();
        check_q("clr_over_load", 8'h00);
        #1 clr = 1'b1;
        #1 check_q("clr_release_hold", 8'h00);
        mode = 3'b000;
    endtask

    task automatic test_random();
        int unsigned exp = q;
        for (int i = 0; i < 400; i++) begin
            int unsigned r = $urandom_range(0, 19);
            if (r == 0) begin
                clr = 1'b0; #1 clr = 1'b1; exp = 0;
            end else if (r == 1) begin
                pre = 1'b0; #1 pre = 1'b1; exp = PV;
            end
            en    = ($urandom_range(0, 4) != 0);
            mode  = 3'($urandom_range(0, 7));
            d     = W'($urandom);
            sl_in = 1'($urandom);
            sr_in = 1'($urandom);
            #1;
            checks++;
            if (tc !== model_tc(exp, mode)) begin
                errors++;
                $display("FAIL rand_tc[%0d]: tc=%b expected %b", i, tc, model_tc(exp, mode));
            end
            exp = model_next(exp, en, mode, d, sl_in, sr_in);
            tick();
            check_q($sformatf("rand_q[%0d]", i), exp);
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_async();
        test_count();
        test_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/universal_reg.md
UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 Parameter PRE_VAL, default all ones (WIDTH bits), value forced by pre.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 clr  input  1  asynchronous active-low clear, forces q to 0.
REQ-005 pre  input  1  asynchronous active-low preset, forces q to PRE_VAL.
REQ-006 en  input  1  synchronous enable; 0 = hold regardless of mode.
REQ-007 mode  input  3  operation select, sampled at rising clk.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sl_in  input  1  serial input for shift-left; enters at bit 0.
REQ-010 sr_in  input  1  serial input for shift-right; enters at bit WIDTH-1.
REQ-011 q  output  WIDTH  register state.
REQ-012 qb  output  WIDTH  bitwise complement of q, always.
REQ-013 tc  output  1  terminal count flag (count feature only).

Function
REQ-014 All state updates except clr/pre occur on the rising edge of clk when en=1 and both clr and pre are deasserted.
REQ-015 mode 000 hold: q unchanged.
REQ-016 mode 001 load: q <= d.
REQ-017 mode 010 shift left: q <= {q[WIDTH-2:0], sl_in}.
REQ-018 mode 011 shift right: q <= {sr_in, q[WIDTH-1:1]}.
REQ-019 mode 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
REQ-020 mode 101 rotate right: q <= {q[0], q[WIDTH-1:1]}.
REQ-021 mode 110/111 count up/down as defined under Configuration; otherwise hold.
REQ-022 Each operation takes effect in exactly one clock; q is registered, no combinational path from d/mode to q.
REQ-023 qb SHALL equal ~q in every state, including during clr/pre and the simultaneous clr+pre case.
REQ-024 en=0 SHALL hold q for any mode, including load.

Reset
REQ-025 clr=0 SHALL set q=0, qb=all ones, tc per REQ-030 immediately, without waiting for clk.
REQ-026 pre=0 with clr=1 SHALL set q=PRE_VAL immediately, without a clk edge.
REQ-027 clr=0 and pre=0 together: clr dominates, q=0; releasing clr while pre is still low SHALL move q to PRE_VAL asynchronously.
REQ-028 While clr or pre is low, clk edges SHALL have no effect; the first rising edge after both deassert applies the normal mode operation.
REQ-029 Assertion of clr or pre mid-operation (any mode, any count value) SHALL override the pending update without glitching qb out of complement.

Configuration
REQ-030 Macro UREG_COUNT_EN: when defined, mode 110 SHALL compute q <= q+1 and mode 111 SHALL compute q <= q-1, both modulo 2^WIDTH (all-ones wraps to 0, 0 wraps to all-ones); tc SHALL be combinationally 1 when (mode=110 and q=all ones) or (mode=111 and q=0), independent of en, else 0.
REQ-031 When UREG_COUNT_EN is undefined, modes 110/111 SHALL hold q, tc SHALL be tied to 0, and no adder logic is instantiated.

Verification (WIDTH=8, PRE_VAL=8'hFF)
REQ-032 clr=0 then clr=1, en=1, mode=001, d=8'hA5, one clk -> q=8'hA5, qb=8'h5A.
REQ-033 q=8'hA5, mode=010, sl_in=1, one clk -> q=8'h4B; mode=101, one clk -> q=8'hA5.
REQ-034 q=8'h3C, pre pulsed low between clk edges -> q=8'hFF before next edge; clr and pre low together -> q=8'h00; release clr only -> q=8'hFF.
REQ-035 UREG_COUNT_EN defined, q=8'hFE, mode=110: after 1 clk q=8'hFF and tc=1, after 2 clks q=8'h00 and tc=0; mode=111 from 8'h00 -> tc=1, next clk q=8'hFF.
REQ-036 UREG_COUNT_EN undefined, q=8'h12, mode=110, 3 clks -> q=8'h12, tc=0.
REQ-037 en=0, mode=001, d=8'h77, 2 clks -> q unchanged; clr asserted during a clk edge with mode=001 -> q=8'h00, load ignored.
